// File: rtl/aes_round_seq.sv
// Round sequencer/arbiter for the shared AES-256 round register: one external load,
// NUM_ROUNDS internal round writes, then a valid/ready handshake for the finished block.
module aes_round_seq #(
    parameter int unsigned NUM_ROUNDS = 14,
    parameter int unsigned ROUND_W    = 4
) (
    input  logic               inClk,
    input  logic               inRstN,
    input  logic               inEncReq,
    input  logic               inDecReq,
    input  logic               inFlush,
    input  logic               inOutReady,
    output logic               outEncAck,
    output logic               outDecAck,
    output logic               outExtEncWr,
    output logic               outExtDecWr,
    output logic               outIntEncWr,
    output logic               outIntDecWr,
    output logic [ROUND_W-1:0] outRound,
    output logic               outLast,
    output logic               outMode,
    output logic               outBusy,
    output logic               outValid
);

    typedef enum logic [1:0] {StIdle, StRound, StDone} stateT;

    localparam logic [ROUND_W-1:0] LastCnt = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] OneCnt  = ROUND_W'(1);

    stateT              state;
    logic [ROUND_W-1:0] cntQ;
    logic               modeQ;
    logic               lastDecQ;
    logic               lastQ;
    logic               busyQ;
    logic               validQ;

    logic canGrant;
    logic pickDec;
    logic grantEnc;
    logic grantDec;
    logic roundWr;

    // Grant is gated by reset so no strobe can leak out while inRstN is low.
    assign canGrant = (state == StIdle) && inRstN && !inFlush;
    assign pickDec  = inDecReq && (!inEncReq || !lastDecQ);
    assign grantDec = canGrant && pickDec;
    assign grantEnc = canGrant && inEncReq && !pickDec;
    assign roundWr  = (state == StRound) && !inFlush;

    assign outEncAck   = grantEnc;
    assign outDecAck   = grantDec;
    assign outExtEncWr = grantEnc;
    assign outExtDecWr = grantDec;
    assign outIntEncWr = roundWr && !modeQ;
    assign outIntDecWr = roundWr && modeQ;
    assign outRound    = cntQ;
    assign outLast     = lastQ;
    assign outMode     = (state == StIdle) ? grantDec : modeQ;
    assign outBusy     = busyQ;
    assign outValid    = validQ;

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state    <= StIdle;
            cntQ     <= '0;
            modeQ    <= 1'b0;
            lastDecQ <= 1'b1;
            lastQ    <= 1'b0;
            busyQ    <= 1'b0;
            validQ   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grantEnc || grantDec) begin
                        state    <= StRound;
                        cntQ     <= OneCnt;
                        modeQ    <= grantDec;
                        lastDecQ <= grantDec;
                        lastQ    <= (NUM_ROUNDS == 1);
                        busyQ    <= 1'b1;
                    end
                end
                StRound: begin
                    if (inFlush) begin
                        state <= StIdle;
                        cntQ  <= '0;
                        lastQ <= 1'b0;
                        busyQ <= 1'b0;
                    end else if (cntQ == LastCnt) begin
                        state  <= StDone;
                        cntQ   <= '0;
                        lastQ  <= 1'b0;
                        validQ <= 1'b1;
                    end else begin
                        cntQ  <= cntQ + OneCnt;
                        lastQ <= ((cntQ + OneCnt) == LastCnt);
                    end
                end
                StDone: begin
                    if (inFlush || inOutReady) begin
                        state  <= StIdle;
                        busyQ  <= 1'b0;
                        validQ <= 1'b0;
                    end
                end
                default: begin
                    state  <= StIdle;
                    cntQ   <= '0;
                    lastQ  <= 1'b0;
                    busyQ  <= 1'b0;
                    validQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
